// File: rtl/boot_loader_pkg.sv
// Shared types and helpers for the parametrised UART boot loader.
package boot_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [3:0] {
    S_LOAD,
    S_WRITE,
    S_CHECK,
    S_WAIT_SCAN,
    S_READ,
    S_LATCH,
    S_SEND,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_e;

  // Byte position within a word for the idx-th byte of the stream.
  function automatic int byte_lane(input int idx, input int nbytes, input int big_endian);
    return (big_endian != 0) ? (nbytes - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/boot_loader_param_word_serializer.sv
// Word-to-byte shifter for readback: presents one lane at a time with
// valid/ready and counts the idle gap after every transferred byte.
module word_serializer
  import boot_loader_pkg::*;
#(
  parameter int WORD_BYTES = 2,
  parameter int BIG_ENDIAN = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_ce,
  input  logic                         i_load,
  input  logic [BYTE_W*WORD_BYTES-1:0] i_word,
  input  logic                         i_send,
  input  logic                         i_gap,
  input  logic                         i_tx_ready,
  output logic [BYTE_W-1:0]            o_tx_byte,
  output logic                         o_tx_valid,
  output logic                         o_xfer,
  output logic                         o_byte_done,
  output logic                         o_last_lane
);

  localparam int W  = BYTE_W * WORD_BYTES;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [W-1:0]  r_word;
  logic [1:0]    r_lane;
  logic [GW-1:0] r_gap;
  logic          w_gap_done;

  assign o_tx_valid  = i_send;
  assign o_xfer      = i_send && i_tx_ready && i_ce;
  assign w_gap_done  = i_gap && i_ce && (r_gap == '0);
  // Without a gap the byte is finished the moment it is accepted.
  assign o_byte_done = (GAP_CYCLES == 0) ? o_xfer : w_gap_done;
  assign o_last_lane = (r_lane == 2'(WORD_BYTES - 1));

  always_comb begin
    o_tx_byte = '0;
    if (i_send) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (byte_lane(int'(r_lane), WORD_BYTES, BIG_ENDIAN) == i) begin
          o_tx_byte = r_word[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
      r_lane <= '0;
      r_gap  <= '0;
    end else if (i_ce) begin
      if (i_load) begin
        r_word <= i_word;
        r_lane <= '0;
      end else if (o_byte_done) begin
        r_lane <= o_last_lane ? 2'd0 : r_lane + 2'd1;
      end
      if (o_xfer) begin
        r_gap <= GW'(GAP_CYCLES - 1);
      end else if (i_gap && (r_gap != '0)) begin
        r_gap <= r_gap - GW'(1);
      end
    end
  end

endmodule

// File: rtl/boot_loader_param.sv
// UART boot loader: packs rx bytes into words, writes program RAM, verifies
// a trailing checksum, then streams RAM back out on scan_memory.
// States: LOAD assemble | WRITE ram write | CHECK checksum | WAIT_SCAN idle | READ strobe | LATCH capture | SEND tx | GAP idle | DONE | ERROR
module boot_loader_param
  import boot_loader_pkg::*;
#(
  parameter int WORD_BYTES = 2,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6,
  parameter int BIG_ENDIAN = 1,
  parameter int GAP_CYCLES = 0,
  parameter int RX_TIMEOUT = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic [7:0]                   rx_byte,
  input  logic                         rx_valid,
  output logic [7:0]                   tx_byte,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  input  logic                         scan_memory,
  output logic                         boot,
  output logic [ADDR_W-1:0]            ram_addr,
  output logic                         ram_enable,
  output logic                         ram_rw,
  output logic [BYTE_W*WORD_BYTES-1:0] ram_in,
  input  logic [BYTE_W*WORD_BYTES-1:0] ram_out,
  output logic                         done,
  output logic                         error
);

  localparam int W    = BYTE_W * WORD_BYTES;
  localparam int TO_W = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

  state_e            r_state, w_next;
  logic [1:0]        r_byte_cnt;
  logic [W-1:0]      r_asm, w_asm_next;
  logic [W-1:0]      r_ram_in;
  logic [ADDR_W-1:0] r_idx;
  logic [7:0]        r_csum;
  logic              r_got_byte;
  logic [TO_W-1:0]   r_to_cnt;

  logic w_last_word, w_word_full, w_accept, w_csum_byte, w_timeout;
  logic w_xfer, w_byte_done, w_last_lane;

  assign w_last_word = (r_idx == ADDR_W'(DEPTH - 1));
  assign w_word_full = (r_byte_cnt == 2'(WORD_BYTES - 1));
  // A byte landing in WRITE belongs to the next word, or is the checksum after the last one.
  assign w_accept    = ce && rx_valid && ((r_state == S_LOAD) || (r_state == S_WRITE && !w_last_word));
  assign w_csum_byte = ce && rx_valid && ((r_state == S_CHECK) || (r_state == S_WRITE && w_last_word));
  assign w_timeout   = (RX_TIMEOUT > 0) && r_got_byte && ce && !rx_valid &&
                       ((r_state == S_LOAD) || (r_state == S_CHECK)) && (r_to_cnt == '0);

  always_comb begin
    w_asm_next = r_asm;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (byte_lane(int'(r_byte_cnt), WORD_BYTES, BIG_ENDIAN) == i) begin
        w_asm_next[i*BYTE_W +: BYTE_W] = rx_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (ce) begin
      case (r_state)
        S_LOAD: begin
          if (w_timeout)                   w_next = S_ERROR;
          else if (w_accept && w_word_full) w_next = S_WRITE;
        end
        S_WRITE: begin
          if (w_csum_byte)                  w_next = (rx_byte == r_csum) ? S_WAIT_SCAN : S_ERROR;
          else if (w_last_word)             w_next = S_CHECK;
          else if (w_accept && w_word_full) w_next = S_WRITE;
          else                              w_next = S_LOAD;
        end
        S_CHECK: begin
          if (w_csum_byte)    w_next = (rx_byte == r_csum) ? S_WAIT_SCAN : S_ERROR;
          else if (w_timeout) w_next = S_ERROR;
        end
        S_WAIT_SCAN: if (scan_memory) w_next = S_READ;
        S_READ:      w_next = S_LATCH;
        S_LATCH:     w_next = S_SEND;
        S_SEND, S_GAP: begin
          if (w_byte_done) begin
            if (!w_last_lane)      w_next = S_SEND;
            else if (!w_last_word) w_next = S_READ;
            else                   w_next = S_DONE;
          end else if (w_xfer) begin
            w_next = S_GAP;
          end
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_ram_in   <= '0;
      r_idx      <= '0;
      r_csum     <= '0;
      r_got_byte <= 1'b0;
      r_to_cnt   <= '0;
    end else if (ce) begin
      if (w_accept) begin
        r_asm      <= w_asm_next;
        r_csum     <= r_csum + rx_byte;
        r_got_byte <= 1'b1;
        r_byte_cnt <= w_word_full ? 2'd0 : r_byte_cnt + 2'd1;
        if (w_word_full) r_ram_in <= w_asm_next;
      end
      if (RX_TIMEOUT > 0) begin
        if (w_accept || w_csum_byte) begin
          r_to_cnt <= TO_W'(RX_TIMEOUT - 1);
        end else if ((r_state == S_LOAD || r_state == S_CHECK) && r_got_byte && (r_to_cnt != '0)) begin
          r_to_cnt <= r_to_cnt - TO_W'(1);
        end
      end
      if (r_state == S_WRITE && !w_last_word) begin
        r_idx <= r_idx + ADDR_W'(1);
      end else if (r_state == S_WAIT_SCAN) begin
        r_idx <= '0;
      end else if (w_byte_done && w_last_lane && !w_last_word) begin
        r_idx <= r_idx + ADDR_W'(1);
      end
    end
  end

  word_serializer #(
    .WORD_BYTES(WORD_BYTES),
    .BIG_ENDIAN(BIG_ENDIAN),
    .GAP_CYCLES(GAP_CYCLES)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .i_ce       (ce),
    .i_load     (r_state == S_LATCH),
    .i_word     (ram_out),
    .i_send     (r_state == S_SEND),
    .i_gap      (r_state == S_GAP),
    .i_tx_ready (tx_ready),
    .o_tx_byte  (tx_byte),
    .o_tx_valid (tx_valid),
    .o_xfer     (w_xfer),
    .o_byte_done(w_byte_done),
    .o_last_lane(w_last_lane)
  );

  assign ram_addr   = r_idx;
  assign ram_in     = r_ram_in;
  assign ram_enable = (r_state == S_WRITE) || (r_state == S_READ);
  assign ram_rw     = (r_state == S_WRITE);
  assign done       = (r_state == S_DONE);
  assign error      = (r_state == S_ERROR);
  assign boot       = (r_state == S_LOAD) || (r_state == S_WRITE) ||
                      (r_state == S_CHECK) || (r_state == S_ERROR);

endmodule

// File: tb/tb_boot_loader_param.sv
// Scoreboard bench: two loaders (big-endian with gap/timeout, little-endian plain)
// share stimulus; a reference model queues expected RAM writes and tx bytes.
module tb_boot_loader_param;

  logic        clk, rst, ce, rx_valid, scan_memory;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_byte    [2];
  logic        tx_valid   [2];
  logic        tx_ready   [2];
  logic        boot       [2];
  logic [1:0]  ram_addr   [2];
  logic        ram_enable [2];
  logic        ram_rw     [2];
  logic [15:0] ram_in     [2];
  logic [15:0] ram_out    [2];
  logic        done       [2];
  logic        error      [2];

  logic [15:0] mem [2][4];
  logic [17:0] q_wr [2][$];
  logic [7:0]  q_tx [2][$];
  logic [7:0]  data_b [8];

  int total = 0, bad = 0;
  bit ce_rand = 0;
  int pend_gap [2], low_cnt [2], tx_pos [2], valid_cnt [2];
  bit prev_stall [2];
  logic [7:0] prev_byte [2];

  boot_loader_param #(.WORD_BYTES(2), .DEPTH(4), .ADDR_W(2), .BIG_ENDIAN(1),
                      .GAP_CYCLES(3), .RX_TIMEOUT(100)) dut0 (
    .clk(clk), .rst(rst), .ce(ce), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .scan_memory(scan_memory), .boot(boot[0]), .ram_addr(ram_addr[0]),
    .ram_enable(ram_enable[0]), .ram_rw(ram_rw[0]), .ram_in(ram_in[0]),
    .ram_out(ram_out[0]), .done(done[0]), .error(error[0]));

  boot_loader_param #(.WORD_BYTES(2), .DEPTH(4), .ADDR_W(2), .BIG_ENDIAN(0),
                      .GAP_CYCLES(0), .RX_TIMEOUT(0)) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .scan_memory(scan_memory), .boot(boot[1]), .ram_addr(ram_addr[1]),
    .ram_enable(ram_enable[1]), .ram_rw(ram_rw[1]), .ram_in(ram_in[1]),
    .ram_out(ram_out[1]), .done(done[1]), .error(error[1]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_enable[d]) begin
        if (ram_rw[d]) mem[d][ram_addr[d]] <= ram_in[d];
        else           ram_out[d] <= mem[d][ram_addr[d]];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int gap_of(input int d);
    return (d == 0) ? 3 : 0;
  endfunction

  // Monitor: write scoreboard, tx scoreboard, hold-stability and gap length.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        pend_gap[d] = 0; low_cnt[d] = 0; tx_pos[d] = 0; valid_cnt[d] = 0; prev_stall[d] = 0;
      end else begin
        if (prev_stall[d]) begin
          check($sformatf("tx_hold_valid dut%0d", d), tx_valid[d], 1);
          check($sformatf("tx_hold_byte dut%0d", d), tx_byte[d], prev_byte[d]);
        end
        if (tx_valid[d]) valid_cnt[d]++;
        if (ce && ram_enable[d] && ram_rw[d]) begin
          if (q_wr[d].size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write dut%0d: got addr=%0h data=%0h, want no write", d, ram_addr[d], ram_in[d]);
          end else begin
            check($sformatf("ram_write dut%0d", d), {ram_addr[d], ram_in[d]}, q_wr[d].pop_front());
          end
        end
        if (ce) begin
          if (tx_valid[d] && pend_gap[d] != 0) begin
            check($sformatf("tx_gap dut%0d pos%0d", d, tx_pos[d]), low_cnt[d],
                  (tx_pos[d] % 2 == 0) ? gap_of(d) + 2 : gap_of(d));
            pend_gap[d] = 0;
          end
          if (tx_valid[d] && tx_ready[d]) begin
            if (q_tx[d].size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_tx dut%0d: got %0h, want no byte", d, tx_byte[d]);
            end else begin
              check($sformatf("tx_byte dut%0d", d), tx_byte[d], q_tx[d].pop_front());
            end
            tx_pos[d]++; pend_gap[d] = 1; low_cnt[d] = 0;
          end else if (!tx_valid[d] && pend_gap[d] != 0) begin
            low_cnt[d]++;
          end
        end
        prev_stall[d] = tx_valid[d] && !(tx_ready[d] && ce);
        prev_byte[d]  = tx_byte[d];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick_ce();
    return ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  function automatic logic [7:0] sum_bytes();
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 8; i++) s = s + data_b[i];
    return s;
  endfunction

  task automatic do_reset();
    rst = 1; ce = 1; rx_valid = 0; scan_memory = 0;
    repeat (2) tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_vals dut%0d", d),
            {boot[d], ram_enable[d], ram_rw[d], ram_addr[d], ram_in[d], tx_valid[d],
             tx_byte[d], done[d], error[d]}, 64'h8000_0000);
    end
    rst = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) begin
      rx_valid = 0; ce = pick_ce(); tick();
    end
    rx_byte = b; rx_valid = 1; ce = 1;
    tick();
    rx_valid = 0; ce = 1;
  endtask

  task automatic do_load(input logic [7:0] csum, input int nb);
    for (int i = 0; i < nb; i++) begin
      if (i % 2 == 1) begin
        q_wr[0].push_back({2'(i / 2), data_b[i-1], data_b[i]});
        q_wr[1].push_back({2'(i / 2), data_b[i], data_b[i-1]});
      end
      send_byte(data_b[i]);
    end
    if (nb == 8) send_byte(csum);
  endtask

  task automatic post_load_checks(input bit ok);
    ce = 1;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("boot_after_load dut%0d", d), boot[d], !ok);
      check($sformatf("error_after_load dut%0d", d), error[d], !ok);
      check($sformatf("writes_pending dut%0d", d), q_wr[d].size(), 0);
    end
  endtask

  task automatic readback(input bit ok, input bit stall);
    bit stalled = 0;
    if (ok) for (int d = 0; d < 2; d++) for (int i = 0; i < 8; i++) q_tx[d].push_back(data_b[i]);
    scan_memory = 1; ce = 1;
    tick();
    scan_memory = 0;
    for (int n = 0; n < 3000; n++) begin
      if (ok && q_tx[0].size() == 0 && q_tx[1].size() == 0 && done[0] && done[1]) break;
      if (!ok && n >= 40) break;
      if (stall && !stalled && tx_valid[0] && tx_byte[0] == 8'h56) begin
        stalled = 1; ce = 1; tx_ready[0] = 0; tx_ready[1] = 1;
        repeat (5) begin
          tick();
          check("stall_valid", tx_valid[0], 1);
          check("stall_byte", tx_byte[0], 8'h56);
        end
      end
      ce = pick_ce();
      tx_ready[0] = stall ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      tx_ready[1] = 1'($urandom_range(0, 3) != 0);
      tick();
    end
    ce = 1;
    if (stall && ok) check("stall_seen", stalled, 1);
    for (int d = 0; d < 2; d++) begin
      if (ok) begin
        check($sformatf("done dut%0d", d), done[d], 1);
        check($sformatf("boot_done dut%0d", d), boot[d], 0);
        check($sformatf("tx_pending dut%0d", d), q_tx[d].size(), 0);
      end else begin
        check($sformatf("no_tx_in_error dut%0d", d), valid_cnt[d], 0);
        check($sformatf("error_sticky dut%0d", d), error[d], 1);
        check($sformatf("boot_error dut%0d", d), boot[d], 1);
        check($sformatf("done_in_error dut%0d", d), done[d], 0);
      end
    end
  endtask

  initial begin
    logic [7:0] csum;
    bit ok;
    rst = 1; ce = 1; rx_valid = 0; rx_byte = 0; scan_memory = 0;
    tx_ready[0] = 1; tx_ready[1] = 1;
    data_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

    // Directed load with correct checksum, then readback with a stall on 0x56.
    do_reset();
    do_load(8'h38, 8);
    post_load_checks(1);
    readback(1, 1);

    // Wrong checksum: error, and readback must stay silent.
    do_reset();
    do_load(8'h39, 8);
    post_load_checks(0);
    readback(0, 0);

    // Load stalls after three bytes: dut0 times out after exactly 100 idle cycles.
    do_reset();
    do_load(8'h00, 3);
    repeat (99) tick();
    check("timeout_early", error[0], 0);
    tick();
    check("timeout_fire", error[0], 1);
    check("timeout_boot", boot[0], 1);
    check("no_timeout_dut1", error[1], 0);
    check("no_timeout_boot1", boot[1], 1);
    check("timeout_writes", q_wr[0].size(), 0);

    // Reset in the middle of a word, then a fresh full load from address 0.
    do_reset();
    do_load(8'h00, 3);
    do_reset();
    do_load(8'h38, 8);
    post_load_checks(1);
    readback(1, 0);

    // Random data, random ce/tx_ready, occasionally corrupted checksum.
    ce_rand = 1;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 8; i++) data_b[i] = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      csum = ok ? sum_bytes() : sum_bytes() + 8'($urandom_range(1, 255));
      do_load(csum, 8);
      post_load_checks(ok);
      readback(ok, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
